skew_feed_ctrl: RTL and testbench
=================================

// Module: skew_feed_ctrl
// PURPOSE
//  Sequences one tile of K input vectors from the operand buffer into the N-lane skew triangle
//  that feeds the systolic array. Issues buffer reads and zero-fills bubbles. Generates a
//  per-lane valid mask aligned with the skewed data. Signals done once the array has drained.
//  Sits between the tile scheduler (start/done) and the skew triangle and operand buffer.
// PARAMETERS
//  N          8   array dimension = number of lanes = skew depth
//  DATA_W     32  lane data width
//  ADDR_W     8   operand buffer address width; K range 0..2**ADDR_W
//  ARRAY_LAT  8   cycles from the last skewed lane entering the array to the last result valid
// PORTS
//  clk        in   1              clock; all state updates on rising edge
//  rst        in   1              synchronous, active-high reset
//  start      in   1              tile request; sampled only in IDLE
//  base_addr  in   ADDR_W         first buffer address of the tile
//  num_rows   in   ADDR_W+1       K = number of vectors in the tile
//  hold       in   1              backpressure; pauses reads in FEED only
//  rd_en      out  1              buffer read strobe
//  rd_addr    out  ADDR_W         buffer read address
//  rd_data    in   DATA_W x [N]   buffer read data, valid 1 cycle after rd_en
//  feed_data  out  DATA_W x [N]   to skew triangle input; rd_data when feed_valid, else 0
//  feed_valid out  1              feed_data carries a real vector this cycle
//  lane_valid out  N              lane_valid[i] = feed_valid delayed i cycles (skew-aligned)
//  busy       out  1              high in every state except IDLE
//  done       out  1              1-cycle pulse when the tile is fully drained
// BEHAVIOUR
//  - Reset: state=IDLE. rd_en, feed_valid, lane_valid, busy and done are 0; rd_addr=0;
//    counters=0. Reset mid-tile aborts the tile with no done pulse.
//  - FSM: IDLE -> FEED on start && num_rows!=0. Latch base_addr and K; set addr=base, remaining=K.
//    IDLE -> DONE on start && num_rows==0: no reads, done pulses the next cycle.
//    FEED -> DRAIN on the cycle the last read issues (remaining==1 && !hold).
//    DRAIN -> DONE when drain_cnt reaches N-1+ARRAY_LAT. drain_cnt counts from the cycle
//    after the last feed_valid. DONE -> IDLE always (1 cycle; done=1 only here).
//  - FEED: rd_en = !hold. Each issued read sets rd_addr++ and remaining--.
//    rd_addr wraps modulo 2**ADDR_W. hold=1 inserts a bubble; no read and counters frozen.
//  - feed_valid is rd_en registered (1-cycle read latency). feed_data is combinational from rd_data.
//    When feed_valid=0, feed_data is forced to all zeros so bubbles inject zeros into the array.
//  - lane_valid: lane_valid[0] = feed_valid. lane_valid[i] is registered from lane_valid[i-1].
//    The shift runs every cycle, including IDLE; it never stalls, matching the free-running skew.
//  - hold is ignored outside FEED. start is ignored while busy (no queueing).
//  - Latency: exactly K reads total. With hold never asserted, done rises
//    K+1+(N-1+ARRAY_LAT)+1 cycles after the start cycle.
//  - K = 2**ADDR_W is legal; the address wraps back to base.
// STRUCTURE
//  - Shared package tpu_pkg: typedef enum logic [1:0] {IDLE,FEED,DRAIN,DONE} feed_state_t;
//    constant DATA_W=32.
//  - One sub-module, valid_skew #(N): an N-stage 1-bit shift register with sync active-high rst
//    that produces lane_valid.
//  - Remainder in this module: the FSM, address/remaining counters and the drain counter.
//    drain_cnt width is $clog2(N+ARRAY_LAT).
// TESTING
//  1. N=4, ARRAY_LAT=2, base=0x10, K=3, hold=0 -> rd_addr 0x10,0x11,0x12 on consecutive cycles.
//     feed_valid 3 cycles; lane_valid[3] high 3 cycles starting 3 cycles later.
//     done pulses 1 cycle, 10 cycles after start; busy falls with done.
//  2. Same tile, hold=1 on the 2nd FEED cycle -> exactly 3 reads; one zero bubble on feed_data
//     with feed_valid=0; lane_valid shows the gap shifting through; done 1 cycle later than in test 1.
//  3. base=0xFE, K=4 -> rd_addr 0xFE,0xFF,0x00,0x01 (wrap); done still pulses once.
//  4. K=0 -> no rd_en; done pulses 1 cycle after start; busy high only in DONE.
//  5. start pulsed during FEED and DRAIN -> ignored; a single done; a new start after IDLE is accepted.
//  6. rst asserted mid-FEED -> next cycle all outputs 0, state IDLE, no done.
//     A subsequent start behaves as in test 1.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU types: feed controller state encoding and default lane width.
package tpu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_t;

endpackage

// File: rtl/skew_feed_ctrl_if.sv
// Scheduler / operand buffer / skew triangle signals of the skew feed controller.
interface skew_feed_ctrl_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic                         start;
    logic [ADDR_W-1:0]            base_addr;
    logic [ADDR_W:0]              num_rows;
    logic                         hold;
    logic                         rd_en;
    logic [ADDR_W-1:0]            rd_addr;
    logic [N-1:0][DATA_W-1:0]     rd_data;
    logic [N-1:0][DATA_W-1:0]     feed_data;
    logic                         feed_valid;
    logic [N-1:0]                 lane_valid;
    logic                         busy;
    logic                         done;

    // Scheduler / buffer side
    modport master (
        output start, base_addr, num_rows, hold, rd_data,
        input  rd_en, rd_addr, feed_data, feed_valid, lane_valid, busy, done
    );

    // Controller side
    modport slave (
        input  start, base_addr, num_rows, hold, rd_data,
        output rd_en, rd_addr, feed_data, feed_valid, lane_valid, busy, done
    );
endinterface

// File: rtl/skew_feed_ctrl_valid_skew.sv
// Free-running valid shifter: lane i sees the feed valid delayed by i cycles.
module valid_skew #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in,
    output logic [N-1:0] out
);
    logic [N-2:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= in;
            for (int i = 1; i < int'(N) - 1; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign out = {sr, in};
endmodule

// File: rtl/skew_feed_ctrl.sv
// Streams one tile of K vectors from the operand buffer into the skew triangle,
// then waits for the array to drain before pulsing done.
module skew_feed_ctrl
    import tpu_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned DATA_W    = tpu_pkg::DATA_W,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned ARRAY_LAT = 8
) (
    input  logic            clk,
    input  logic            rst,
    skew_feed_ctrl_if.slave bus
);
    localparam int unsigned DRAIN_LEN = N - 1 + ARRAY_LAT;
    localparam int unsigned CNT_W     = $clog2(N + ARRAY_LAT);

    feed_state_t       state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [CNT_W-1:0]  drain_cnt;
    logic              feed_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_c;

    assign rd_en_c = (state == FEED) && !bus.hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            drain_cnt    <= '0;
            feed_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            feed_valid_q <= rd_en_c;
            done_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.num_rows != '0) begin
                            state     <= FEED;
                            addr      <= bus.base_addr;
                            remaining <= bus.num_rows;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (rd_en_c) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - (ADDR_W+1)'(1);
                        if (remaining == (ADDR_W+1)'(1)) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // Count only once the last real vector has left the feed register
                    if (!feed_valid_q) begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                        if (drain_cnt == CNT_W'(DRAIN_LEN - 1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    drain_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    valid_skew #(.N(N)) u_valid_skew (
        .clk (clk),
        .rst (rst),
        .in  (feed_valid_q),
        .out (bus.lane_valid)
    );

    assign bus.rd_en      = rd_en_c;
    assign bus.rd_addr    = addr;
    assign bus.feed_valid = feed_valid_q;
    assign bus.feed_data  = feed_valid_q ? bus.rd_data : {N{DATA_W'(0)}};
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Scoreboard bench for skew_feed_ctrl: expected reads, feeds, lane valids and done
// cycles are queued at stimulus time and popped by a negedge monitor.
module tb_skew_feed_ctrl;
    localparam int unsigned N         = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned ARRAY_LAT = 2;

    typedef logic [N-1:0][DATA_W-1:0] vec_t;
    typedef struct {
        int          cyc;
        logic [7:0]  addr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    int   busy_lo = 1;
    int   busy_hi = 0;

    ev_t  exp_rd[$];
    ev_t  exp_fv[$];
    int   exp_lv[N][$];
    int   exp_done[$];

    skew_feed_ctrl_if #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    skew_feed_ctrl #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ARRAY_LAT(ARRAY_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t pattern(logic [7:0] a);
        vec_t v;
        for (int j = 0; j < int'(N); j++) v[j] = 32'hC0DE_0000 | (32'(a) << 4) | 32'(j);
        return v;
    endfunction

    // Operand buffer: one-cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= pattern(bus.rd_addr);
        else           bus.rd_data <= {N{32'hDEAD_BEEF}};
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents an output
    ev_t m_ev;
    int  m_c;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rd_en === 1'b1) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    m_ev = exp_rd.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(m_ev.cyc));
                    check("rd_addr", 64'(bus.rd_addr), 64'(m_ev.addr));
                end
            end
            if (bus.feed_valid === 1'b1) begin
                if (exp_fv.size() == 0) check("fv_unexpected", 1, 0);
                else begin
                    m_ev = exp_fv.pop_front();
                    check("fv_cycle", 64'(cyc), 64'(m_ev.cyc));
                    tests++;
                    if (bus.feed_data !== pattern(m_ev.addr)) begin
                        fails++;
                        $display("FAIL feed_data @cyc %0d: got %h expected %h", cyc, bus.feed_data, pattern(m_ev.addr));
                    end
                end
            end else begin
                tests++;
                if (bus.feed_data !== '0) begin
                    fails++;
                    $display("FAIL feed_zero @cyc %0d: got %h expected 0", cyc, bus.feed_data);
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (bus.lane_valid[i] === 1'b1) begin
                    if (exp_lv[i].size() == 0) check("lv_unexpected", 64'(i), 64'(99));
                    else begin
                        m_c = exp_lv[i].pop_front();
                        check("lv_cycle", 64'(cyc), 64'(m_c));
                    end
                end
            end
            if (bus.done === 1'b1) begin
                if (exp_done.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    m_c = exp_done.pop_front();
                    check("done_cycle", 64'(cyc), 64'(m_c));
                end
            end
            check("busy", 64'(bus.busy), 64'((cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0));
        end
    end

    task automatic go_to(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected events for a tile started in cycle s; hold_at is a relative cycle (0 = none)
    task automatic plan(int s, int base, int k, int hold_at, output int done_c);
        ev_t e;
        int  c = s + 1;
        int  last = s;
        for (int i = 0; i < k; i++) begin
            if (hold_at != 0 && c == s + hold_at) c++;
            e.cyc = c;     e.addr = 8'(base + i); exp_rd.push_back(e);
            e.cyc = c + 1; exp_fv.push_back(e);
            for (int l = 0; l < int'(N); l++) exp_lv[l].push_back(c + 1 + l);
            last = c;
            c++;
        end
        done_c = (k == 0) ? s + 1 : last + 2 + int'(N - 1 + ARRAY_LAT);
        exp_done.push_back(done_c);
        busy_lo = s + 1;
        busy_hi = done_c;
    endtask

    task automatic start_tile(int base, int k, int hold_at, output int done_c);
        int s = cyc;
        bus.base_addr = 8'(base);
        bus.num_rows  = 9'(k);
        bus.start     = 1'b1;
        plan(s, base, k, hold_at, done_c);
        go_to(s + 1);
        bus.start = 1'b0;
        if (hold_at != 0) begin
            go_to(s + hold_at);
            bus.hold = 1'b1;
            go_to(s + hold_at + 1);
            bus.hold = 1'b0;
        end
    endtask

    task automatic check_empty(string name);
        int lv = 0;
        for (int i = 0; i < int'(N); i++) lv += exp_lv[i].size();
        check({name, "_rd_left"}, 64'(exp_rd.size()), 0);
        check({name, "_fv_left"}, 64'(exp_fv.size()), 0);
        check({name, "_lv_left"}, 64'(lv), 0);
        check({name, "_done_left"}, 64'(exp_done.size()), 0);
    endtask

    task automatic check_idle_outputs(string name);
        check({name, "_rd_en"}, 64'(bus.rd_en), 0);
        check({name, "_rd_addr"}, 64'(bus.rd_addr), 0);
        check({name, "_feed_valid"}, 64'(bus.feed_valid), 0);
        check({name, "_lane_valid"}, 64'(bus.lane_valid), 0);
        check({name, "_busy"}, 64'(bus.busy), 0);
        check({name, "_done"}, 64'(bus.done), 0);
        check({name, "_feed_data"}, 64'(bus.feed_data == '0), 1);
    endtask

    initial begin
        int s;
        int d;
        int d2;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0; bus.hold = 1'b0;
        bus.rd_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        mon_en = 1'b1;
        @(posedge clk); #1;

        // 1: basic tile
        start_tile(8'h10, 3, 0, d);
        go_to(d + 2); check_empty("t1");

        // 2: single hold bubble on the 2nd FEED cycle
        start_tile(8'h10, 3, 2, d);
        go_to(d + 2); check_empty("t2");

        // 3: address wrap
        start_tile(8'hFE, 4, 0, d);
        go_to(d + 2); check_empty("t3");

        // 4: empty tile
        start_tile(8'h40, 0, 0, d);
        go_to(d + 2); check_empty("t4");

        // 5: starts (and hold) outside IDLE/FEED ignored; back-to-back start from IDLE accepted
        s = cyc;
        start_tile(8'h20, 3, 0, d);
        go_to(s + 2); bus.base_addr = 8'h80; bus.num_rows = 9'd5; bus.start = 1'b1;
        go_to(s + 3); bus.start = 1'b0;
        go_to(s + 6); bus.start = 1'b1; bus.hold = 1'b1;
        go_to(s + 7); bus.start = 1'b0; bus.hold = 1'b0;
        go_to(d + 1);
        start_tile(8'h30, 2, 0, d2);
        go_to(d2 + 2); check_empty("t5");

        // 6: reset mid-FEED aborts without done
        s = cyc;
        bus.base_addr = 8'h10; bus.num_rows = 9'd3; bus.start = 1'b1;
        begin
            ev_t e;
            e.cyc = s + 1; e.addr = 8'h10; exp_rd.push_back(e);
            e.cyc = s + 2; e.addr = 8'h11; exp_rd.push_back(e);
            e.cyc = s + 2; e.addr = 8'h10; exp_fv.push_back(e);
            exp_lv[0].push_back(s + 2);
            busy_lo = s + 1; busy_hi = s + 2;
        end
        go_to(s + 1); bus.start = 1'b0;
        go_to(s + 2); rst = 1'b1;
        go_to(s + 3); rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("t6");
        @(posedge clk); #1;
        go_to(s + 8); check_empty("t6");
        start_tile(8'h10, 3, 0, d);
        go_to(d + 2); check_empty("t6b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
